// File: rtl/axu_mem_pkg.sv
// Shared definitions for the Axolotl memory-port arbiter.
// State encoding, access-size codes and default watchdog limit.
package axu_mem_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY0 = 2'd1;
  localparam logic [1:0] ST_BUSY1 = 2'd2;

  localparam logic [1:0] ASZ_BYTE = 2'd0;
  localparam logic [1:0] ASZ_HALF = 2'd1;
  localparam logic [1:0] ASZ_WORD = 2'd2;

  localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/axu_mem_watchdog.sv
// Bus watchdog: counts stalled cycles of one memory access.
// Built only when AXU_ARB_TIMEOUT_EN is defined.
module axu_mem_watchdog
  import axu_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/axu_mem_arbiter.sv
// Two-port registered arbiter for the shared memory port.
// Optional bus watchdog enabled by AXU_ARB_TIMEOUT_EN.
module axu_mem_arbiter
  import axu_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        re0,
  input  logic [1:0]  asize0,
  input  logic [31:0] addr0,
  output logic        ready0,
  output logic [31:0] rdata0,
  output logic        err0,
  input  logic        re1,
  input  logic        we1,
  input  logic [1:0]  asize1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ready1,
  output logic [31:0] rdata1,
  output logic        err1,
  output logic        re2,
  output logic        we2,
  output logic [1:0]  asize2,
  output logic [31:0] addr2,
  output logic [31:0] wdata2,
  input  logic [31:0] rdata2,
  input  logic        ready2
);

  logic [1:0] state;
  logic req0, req1, busy, done, expire;
  logic grant0, grant1, go_idle;

  assign req0 = re0;
  assign req1 = re1 | we1;
  assign busy = (state != ST_IDLE);
  assign done = busy & (ready2 | expire);

`ifdef AXU_ARB_TIMEOUT_EN
  axu_mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (grant0 | grant1),
    .en      (busy & ~ready2),
    .expired (expire)
  );
`else
  logic timeout_unused;
  assign timeout_unused = TIMEOUT[0];
  assign expire = 1'b0;
`endif

  // The completing port is excluded from the handover arbitration.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case (1'b1)
      state == ST_IDLE: begin
        grant1 = req1;
        grant0 = ~req1 & req0;
      end
      state == ST_BUSY0: grant1 = done & req1;
      state == ST_BUSY1: grant0 = done & req0;
      default: ;
    endcase
  end

  assign go_idle = done & ~grant0 & ~grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      re2    <= 1'b0;
      we2    <= 1'b0;
      asize2 <= '0;
      addr2  <= '0;
      wdata2 <= '0;
    end else if (grant1) begin
      state  <= ST_BUSY1;
      re2    <= re1 & ~we1;
      we2    <= we1;
      asize2 <= asize1;
      addr2  <= addr1;
      wdata2 <= wdata1;
    end else if (grant0) begin
      state  <= ST_BUSY0;
      re2    <= 1'b1;
      we2    <= 1'b0;
      asize2 <= asize0;
      addr2  <= addr0;
    end else if (go_idle) begin
      state  <= ST_IDLE;
      re2    <= 1'b0;
      we2    <= 1'b0;
    end
  end

  assign ready0 = ~rst & (state == ST_BUSY0) & ready2;
  assign ready1 = ~rst & (state == ST_BUSY1) & ready2;
  assign err0   = ~rst & (state == ST_BUSY0) & expire & ~ready2;
  assign err1   = ~rst & (state == ST_BUSY1) & expire & ~ready2;
  assign rdata0 = ready0 ? rdata2 : '0;
  assign rdata1 = ready1 ? rdata2 : '0;

endmodule

// File: tb/tb_axu_mem_arbiter.sv
// Scoreboard bench for axu_mem_arbiter (TIMEOUT=4).
// Watchdog scenarios run only when AXU_ARB_TIMEOUT_EN is defined.
module tb_axu_mem_arbiter;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        re0, re1, we1, ready2;
  logic [1:0]  asize0, asize1;
  logic [31:0] addr0, addr1, wdata1, rdata2;
  logic        ready0, ready1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        re2, we2;
  logic [1:0]  asize2;
  logic [31:0] addr2, wdata2;

  exp_t sb[$];
  int n_total = 0;
  int n_pass  = 0;

  axu_mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .re0(re0), .asize0(asize0), .addr0(addr0),
    .ready0(ready0), .rdata0(rdata0), .err0(err0),
    .re1(re1), .we1(we1), .asize1(asize1), .addr1(addr1),
    .wdata1(wdata1), .ready1(ready1), .rdata1(rdata1), .err1(err1),
    .re2(re2), .we2(we2), .asize2(asize2), .addr2(addr2),
    .wdata2(wdata2), .rdata2(rdata2), .ready2(ready2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic p, input logic e,
                      input logic [31:0] d, input logic [31:0] a);
    exp_t x;
    x.port = p; x.err = e; x.rdata = d; x.addr = a;
    sb.push_back(x);
  endtask

  // Monitor: every completion or abort must match the next queued entry.
  always @(negedge clk) begin
    if (ready0 | ready1 | err0 | err1) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {ready0, ready1, err0, err1}, 32'h0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("port", 32'(ready1 | err1), 32'(x.port));
        chk("err", 32'(err0 | err1), 32'(x.err));
        chk("rdata", x.port ? rdata1 : rdata0, x.rdata);
        chk("addr2", addr2, x.addr);
      end
    end
  end

  initial begin
    rst = 1'b1; re0 = 0; re1 = 0; we1 = 0; ready2 = 0;
    asize0 = 2'd2; asize1 = 2'd2;
    addr0 = '0; addr1 = '0; wdata1 = '0; rdata2 = '0;
    tick(); tick();
    chk("rst_re2", 32'(re2), 0);
    chk("rst_we2", 32'(we2), 0);
    chk("rst_addr2", addr2, 0);
    chk("rst_wdata2", wdata2, 0);
    chk("rst_ready", {ready0, ready1, err0, err1}, 0);
    rst = 1'b0;

    // single port-0 read, zero wait states
    re0 = 1; addr0 = 32'h100;
    tick();
    re0 = 0;
    chk("p0_re2", 32'(re2), 1);
    chk("p0_addr2", addr2, 32'h100);
    ready2 = 1; rdata2 = 32'h1111_2222;
    push(0, 0, 32'h1111_2222, 32'h100);
    tick();
    ready2 = 0;
    chk("idle_re2", 32'(re2), 0);

    // tie: port 1 write wins, then bubble-free handover to port 0
    re0 = 1; addr0 = 32'h140;
    we1 = 1; addr1 = 32'h200; wdata1 = 32'hDEAD_BEEF;
    tick();
    chk("tie_we2", 32'(we2), 1);
    chk("tie_re2", 32'(re2), 0);
    chk("tie_wdata2", wdata2, 32'hDEAD_BEEF);
    addr1 = 32'h300;
    tick();
    chk("stable_addr2", addr2, 32'h200);
    ready2 = 1; rdata2 = 32'h0;
    push(1, 0, 32'h0, 32'h200);
    tick();
    we1 = 0;
    chk("handover_re2", 32'(re2), 1);
    chk("handover_addr2", addr2, 32'h140);
    rdata2 = 32'hA5A5_A5A5;
    push(0, 0, 32'hA5A5_A5A5, 32'h140);
    tick();
    re0 = 0; ready2 = 0;
    chk("tie_idle_re2", 32'(re2), 0);

    // fairness: continuous contention, always-ready memory
    re0 = 1; addr0 = 32'h400; re1 = 1; addr1 = 32'h800;
    tick();
    ready2 = 1;
    for (int i = 0; i < 8; i++) begin
      rdata2 = 32'h1000 + 32'(i);
      if (i % 2 == 0) push(1, 0, 32'h1000 + 32'(i), 32'h800);
      else            push(0, 0, 32'h1000 + 32'(i), 32'h400);
      if (i == 7) begin re0 = 0; re1 = 0; end
      tick();
    end
    ready2 = 0;
    chk("fair_idle_re2", 32'(re2), 0);

    // reset in the middle of a port-0 access
    re0 = 1; addr0 = 32'h500;
    tick();
    re0 = 0; rst = 1; ready2 = 1; rdata2 = 32'h7777_7777;
    #1;
    chk("midrst_ready0", 32'(ready0), 0);
    chk("midrst_rdata0", rdata0, 0);
    tick();
    rst = 0; ready2 = 0;
    chk("midrst_re2", 32'(re2), 0);

`ifdef AXU_ARB_TIMEOUT_EN
    // port 1 never completes: abort in the 4th busy cycle
    re1 = 1; addr1 = 32'h600; re0 = 1; addr0 = 32'h700;
    tick();
    tick(); tick(); tick();
    push(1, 1, 32'h0, 32'h600);
    tick();
    re1 = 0;
    chk("to_handover_addr2", addr2, 32'h700);
    chk("to_handover_re2", 32'(re2), 1);
    ready2 = 1; rdata2 = 32'h0BAD_F00D;
    re1 = 1; addr1 = 32'h610;
    push(0, 0, 32'h0BAD_F00D, 32'h700);
    tick();
    re0 = 0; ready2 = 0;
    chk("to2_addr2", addr2, 32'h610);
    tick(); tick(); tick();
    ready2 = 1; rdata2 = 32'h0000_CAFE;
    push(1, 0, 32'h0000_CAFE, 32'h610);
    tick();
    re1 = 0; ready2 = 0;
    chk("to2_idle_re2", 32'(re2), 0);
`endif

    tick(); tick();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
